// File: rtl/uart_transmitter.sv
// UART transmitter: byte FIFO feeding an 8N1 serial framer.
// Each bit lasts CLOCKS_PER_BIT cycles and serial_tx is driven from a register.
module uart_transmitter #(
  parameter int CLOCKS_PER_BIT = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          data_valid,
  input  logic [7:0]                    data,
  output logic                          data_ready,
  output logic                          serial_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count_q;
  logic              push;
  logic              pop;

  tx_state_t         state, state_next;
  logic [BAUD_W-1:0] baud_cnt, baud_next;
  logic [2:0]        bit_idx, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_q, tx_next;

  // Readiness depends only on the registered count, never on a same-cycle pop.
  assign data_ready = (count_q < FIFO_FULL);
  assign push       = data_valid && data_ready;
  assign fifo_count = count_q;
  assign serial_tx  = tx_q;
  assign busy       = (state != IDLE) || (count_q != '0);

  // Storage array; contents are don't-care until written, so it needs no reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= data;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Framer state register; reset aborts any frame and forces the line high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_q      <= 1'b1;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= bit_next;
      shift_reg <= shift_next;
      tx_q      <= tx_next;
    end
  end

  // Next-state logic; tx_next is the level the line takes after the coming edge.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift_reg;
    tx_next    = tx_q;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (count_q != '0) begin
          pop        = 1'b1;
          shift_next = fifo_mem[rd_ptr];
          state_next = START;
          tx_next    = 1'b0;
          baud_next  = '0;
          bit_next   = '0;
        end
      end

      START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = {1'b1, shift_reg[7:1]};
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next   = bit_idx + 3'd1;
            tx_next    = shift_reg[0];
            shift_next = {1'b1, shift_reg[7:1]};
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_next = '0;
          bit_next  = '0;
          if (count_q != '0) begin
            pop        = 1'b1;
            shift_next = fifo_mem[rd_ptr];
            state_next = START;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 5: clock cycles per serial bit; legal values >= 2.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: input FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port data_valid, input, 1 bit: the upstream has a byte to send.
REQ-006 SHALL have port data, input, 8 bits: the byte to send, qualified by data_valid.
REQ-007 SHALL have port data_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 SHALL have port serial_tx, output, 1 bit: the serial line; idles high.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of bytes queued, excluding the byte in flight.

Function
REQ-011 SHALL push data into the FIFO on a rising edge where data_valid && data_ready.
REQ-012 SHALL drive data_ready = (fifo_count < FIFO_DEPTH), with no dependence on a same-cycle pop.
REQ-013 SHALL hold data_ready low when the FIFO is full, and SHALL ignore data_valid in that state.
REQ-014 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-015 SHALL handle a simultaneous push and pop by leaving fifo_count unchanged and keeping the data in order.
REQ-016 SHALL implement the states IDLE, START, DATA and STOP.
REQ-017 SHALL, in IDLE with fifo_count > 0, pop the head byte into a shift register at the next edge, enter START, and drive serial_tx low from that edge.
REQ-018 SHALL give a latency of one edge: a byte pushed at edge N into an empty FIFO while IDLE SHALL make serial_tx low after edge N+1.
REQ-019 SHALL hold each bit for exactly CLOCKS_PER_BIT cycles, timed by a baud counter that counts 0..CLOCKS_PER_BIT-1 and resets on every bit boundary.
REQ-020 SHALL drive the START bit as 0.
REQ-021 SHALL send DATA as 8 bits, LSB first, tracked by a bit index 0..7.
REQ-022 SHALL drive the STOP bit as 1.
REQ-023 SHALL make a frame exactly 10*CLOCKS_PER_BIT cycles long.
REQ-024 SHALL, at the end of STOP with fifo_count > 0, pop and enter START at the same edge, leaving no idle gap between frames.
REQ-025 SHALL, at the end of STOP with fifo_count = 0, enter IDLE with serial_tx high.
REQ-026 SHALL NOT let FIFO writes during a frame alter the byte in flight.
REQ-027 SHALL register serial_tx, so that it has no combinational glitches.
REQ-028 SHALL assert busy = (state != IDLE) || (fifo_count != 0).

Reset
REQ-029 SHALL, while reset is high and regardless of clock, hold: state IDLE, serial_tx = 1, data_ready = 1, busy = 0, fifo_count = 0, FIFO pointers 0, baud and bit counters 0.
REQ-030 SHALL, on reset mid-frame, abort the frame, drive the line high immediately, and discard all queued bytes.
REQ-031 SHALL resume normal operation at the first rising edge after reset deasserts.

Verification (CLOCKS_PER_BIT=5, FIFO_DEPTH=4)
REQ-032 SHALL cover a single byte: push 0x53 while IDLE -> serial_tx is 0,1,1,0,0,1,0,1,0,1, each level for 5 cycles, low one edge after the push; busy falls after 50 cycles.
REQ-033 SHALL cover back-to-back bytes: push 0x11 then 0x22 on consecutive edges -> 100 contiguous cycles carrying both frames, with no high gap beyond the stop bit.
REQ-034 SHALL cover FIFO full: hold data_valid with 6 distinct bytes -> 5 accepted, data_ready low with fifo_count=4, the 6th accepted one edge after the first frame's STOP ends; all 6 transmitted in order.
REQ-035 SHALL cover reset mid-frame: assert reset during data bit 3 of 0xA5 with 2 bytes queued -> serial_tx high immediately, fifo_count=0, and no further frames after release.
REQ-036 SHALL cover loopback: serial_tx wired to the team's UART receiver with the same CLOCKS_PER_BIT, sending 0x00, 0xFF, 0xA5 -> the receiver reports exactly those 3 bytes, in order.
REQ-037 SHALL cover idle behaviour: run 200 cycles after reset with no data_valid -> serial_tx stays 1 and busy stays 0 throughout.
